charlieplex_scan: RTL



---
 rtl/charlieplex_scan.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/charlieplex_scan.sv
// Wishbone-controlled scan sequencer for a 7-pin charlieplexed LED matrix (42 LEDs).
// Define CHARLIEPLEX_PWM_EN to add the BRIGHT register and per-dwell column PWM.
module charlieplex_scan #(
   parameter int unsigned DWELL_CYCLES = 4800,
   parameter int unsigned BLANK_CYCLES = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wb_cyc_i,
   input  logic       wb_stb_i,
   input  logic       wb_we_i,
   input  logic [3:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o,
   output logic [6:0] charlieplex_oe,
   output logic [6:0] charlieplex_o,
   output logic       frame_start
);
   localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

   logic [5:0]      r_row_mask [7];
   logic            r_en;
   logic [7:0]      r_bright;
   logic            r_ack;
   logic [7:0]      r_dat;
   state_e          r_state, w_state_nx;
   logic [CntW-1:0] r_cnt, w_cnt_nx;
   logic [2:0]      r_row, w_row_nx;
   logic [5:0]      r_shadow, w_mask_sel, w_mask;
   logic [7:0]      r_pwm, w_pwm_nx;
   logic            w_enter, w_cols_on, w_req, w_frame_nx;
   logic [7:0]      w_rd_dat;
   logic [6:0]      w_oe_nx, w_o_nx;
   logic [6:0]      r_oe, r_o;
   logic            r_frame;

   assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;

   always_comb begin
      w_rd_dat = 8'h00;
      for (int i = 0; i < 7; i++) begin
         if (wb_adr_i == 4'(i)) w_rd_dat = {2'b00, r_row_mask[i]};
      end
      if (wb_adr_i == 4'd7) w_rd_dat = {7'b0, r_en};
`ifdef CHARLIEPLEX_PWM_EN
      if (wb_adr_i == 4'd8) w_rd_dat = r_bright;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack    <= 1'b0;
         r_dat    <= 8'h00;
         r_en     <= 1'b0;
         r_bright <= 8'hFF;
         for (int i = 0; i < 7; i++) r_row_mask[i] <= 6'h00;
      end else begin
         r_ack <= w_req;
         r_dat <= w_req ? w_rd_dat : 8'h00;
         if (w_req && wb_we_i) begin
            for (int i = 0; i < 7; i++) begin
               if (wb_adr_i == 4'(i)) r_row_mask[i] <= wb_dat_i[5:0];
            end
            if (wb_adr_i == 4'd7) r_en <= wb_dat_i[0];
`ifdef CHARLIEPLEX_PWM_EN
            if (wb_adr_i == 4'd8) r_bright <= wb_dat_i;
`endif
         end
      end
   end

`ifndef CHARLIEPLEX_PWM_EN
   logic w_unused_dat;
   assign w_unused_dat = ^wb_dat_i[7:6];
`endif

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_row_nx   = r_row;
      w_enter    = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_cnt_nx = '0;
            if (r_en) w_state_nx = StBlank;
         end
         StBlank: begin
            if (r_cnt == CntW'(BLANK_CYCLES - 1)) begin
               w_state_nx = StDrive;
               w_cnt_nx   = '0;
               w_enter    = 1'b1;
            end
         end
         StDrive: begin
            if (r_cnt == CntW'(DWELL_CYCLES - 1)) begin
               w_state_nx = StBlank;
               w_cnt_nx   = '0;
               w_row_nx   = (r_row == 3'd6) ? 3'd0 : r_row + 3'd1;
            end
         end
         default: w_state_nx = StIdle;
      endcase
      // Disable wins over everything and parks the scan at row 0.
      if (!r_en) begin
         w_state_nx = StIdle;
         w_cnt_nx   = '0;
         w_row_nx   = 3'd0;
         w_enter    = 1'b0;
      end
   end

   always_comb begin
      w_mask_sel = 6'h00;
      for (int i = 0; i < 7; i++) begin
         if (r_row == 3'(i)) w_mask_sel = r_row_mask[i];
      end
      w_mask   = w_enter ? w_mask_sel : r_shadow;
      w_pwm_nx = w_enter ? 8'h00 : r_pwm + 8'h01;
`ifdef CHARLIEPLEX_PWM_EN
      w_cols_on = (w_pwm_nx < r_bright);
`else
      w_cols_on = 1'b1;
`endif
      w_oe_nx    = 7'h00;
      w_o_nx     = 7'h00;
      w_frame_nx = w_enter && (r_row == 3'd0);
      if (w_state_nx == StDrive) begin
         for (int r = 0; r < 7; r++) begin
            if (r_row == 3'(r)) begin
               w_oe_nx[r] = 1'b1;
               w_o_nx[r]  = 1'b1;
            end
         end
         // Column c skips over the row pin, so it lands on pin c or c+1.
         for (int c = 0; c < 6; c++) begin
            if (w_mask[c] && w_cols_on) begin
               if (3'(c) < r_row) w_oe_nx[c] = 1'b1;
               else               w_oe_nx[c + 1] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_row    <= 3'd0;
         r_shadow <= 6'h00;
         r_pwm    <= 8'h00;
         r_oe     <= 7'h00;
         r_o      <= 7'h00;
         r_frame  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_row   <= w_row_nx;
         if (w_enter) r_shadow <= w_mask_sel;
         if (w_state_nx == StDrive) r_pwm <= w_pwm_nx;
         r_oe    <= w_oe_nx;
         r_o     <= w_o_nx;
         r_frame <= w_frame_nx;
      end
   end

   assign wb_ack_o       = r_ack;
   assign wb_dat_o       = r_dat;
   assign charlieplex_oe = r_oe;
   assign charlieplex_o  = r_o;
   assign frame_start    = r_frame;

endmodule
